// File: rtl/dsp_mac_pipe.sv
// Pipelined multiply-accumulate: optional input register, product register, accumulator register.
// Per-sample signedness and accumulate mode travel down the pipe with their data.
module dsp_mac_pipe #(
    parameter int A_WIDTH   = 20,
    parameter int B_WIDTH   = 18,
    parameter int ACC_WIDTH = 48,
    parameter int REG_IN    = 1
) (
    input  logic                 clock0,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [A_WIDTH-1:0]   a,
    input  logic [B_WIDTH-1:0]   b,
    input  logic [2:0]           feedback,
    input  logic                 unsigned_a,
    input  logic                 unsigned_b,
    output logic                 out_valid,
    output logic [ACC_WIDTH-1:0] z,
    output logic                 overflow,
    output logic                 parity
);

    localparam int MSB = ACC_WIDTH - 1;

    if (ACC_WIDTH < A_WIDTH + B_WIDTH) begin : g_bad_acc_width
        $error("dsp_mac_pipe: ACC_WIDTH must be at least A_WIDTH+B_WIDTH");
    end
    if (A_WIDTH < 2 || B_WIDTH < 2) begin : g_bad_operand_width
        $error("dsp_mac_pipe: operand widths must be at least 2");
    end

    // Stage 0 outputs (registered or straight from the ports)
    logic                 w_s0_valid;
    logic [A_WIDTH-1:0]   w_s0_a;
    logic [B_WIDTH-1:0]   w_s0_b;
    logic [2:0]           w_s0_fb;
    logic                 w_s0_ua;
    logic                 w_s0_ub;

    if (REG_IN != 0) begin : g_in_reg
        logic               r_valid;
        logic [A_WIDTH-1:0] r_a;
        logic [B_WIDTH-1:0] r_b;
        logic [2:0]         r_fb;
        logic               r_ua;
        logic               r_ub;

        always_ff @(posedge clock0 or negedge reset) begin
            if (!reset) begin
                r_valid <= 1'b0;
                r_a     <= '0;
                r_b     <= '0;
                r_fb    <= '0;
                r_ua    <= 1'b0;
                r_ub    <= 1'b0;
            end else begin
                r_valid <= in_valid;
                r_a     <= a;
                r_b     <= b;
                r_fb    <= feedback;
                r_ua    <= unsigned_a;
                r_ub    <= unsigned_b;
            end
        end

        assign w_s0_valid = r_valid;
        assign w_s0_a     = r_a;
        assign w_s0_b     = r_b;
        assign w_s0_fb    = r_fb;
        assign w_s0_ua    = r_ua;
        assign w_s0_ub    = r_ub;
    end else begin : g_in_bypass
        assign w_s0_valid = in_valid;
        assign w_s0_a     = a;
        assign w_s0_b     = b;
        assign w_s0_fb    = feedback;
        assign w_s0_ua    = unsigned_a;
        assign w_s0_ub    = unsigned_b;
    end

    // One extra bit per operand lets a single signed multiply cover all sign modes.
    logic signed [A_WIDTH:0]   w_a_ext;
    logic signed [B_WIDTH:0]   w_b_ext;
    logic [ACC_WIDTH-1:0]      w_p;

    assign w_a_ext = {~w_s0_ua & w_s0_a[A_WIDTH-1], w_s0_a};
    assign w_b_ext = {~w_s0_ub & w_s0_b[B_WIDTH-1], w_s0_b};
    // Sign-extending before the multiply gives the exact product modulo 2^ACC_WIDTH.
    assign w_p = ACC_WIDTH'(w_a_ext) * ACC_WIDTH'(w_b_ext);

    logic                 r_s1_valid;
    logic [ACC_WIDTH-1:0] r_s1_p;
    logic [2:0]           r_s1_fb;

    always_ff @(posedge clock0 or negedge reset) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_s1_p     <= '0;
            r_s1_fb    <= '0;
        end else begin
            r_s1_valid <= w_s0_valid;
            r_s1_p     <= w_p;
            r_s1_fb    <= w_s0_fb;
        end
    end

    logic [ACC_WIDTH-1:0] r_acc;
    logic                 r_ovf;
    logic                 r_out_valid;
    logic [ACC_WIDTH-1:0] w_sum;
    logic [ACC_WIDTH-1:0] w_diff;
    logic                 w_ovf_add;
    logic                 w_ovf_sub;
    logic [ACC_WIDTH-1:0] w_acc_nxt;
    logic                 w_ovf_nxt;

    assign w_sum     = r_acc + r_s1_p;
    assign w_diff    = r_acc - r_s1_p;
    assign w_ovf_add = (r_acc[MSB] == r_s1_p[MSB]) && (w_sum[MSB] != r_acc[MSB]);
    assign w_ovf_sub = (r_acc[MSB] != r_s1_p[MSB]) && (w_diff[MSB] != r_acc[MSB]);

    always_comb begin
        w_acc_nxt = r_acc;
        w_ovf_nxt = r_ovf;
        if (r_s1_valid) begin
            case (r_s1_fb)
                3'b001: begin
                    w_acc_nxt = w_sum;
                    w_ovf_nxt = r_ovf | w_ovf_add;
                end
                3'b010: begin
                    w_acc_nxt = w_diff;
                    w_ovf_nxt = r_ovf | w_ovf_sub;
                end
                3'b011: begin
                    w_acc_nxt = r_acc;
                    w_ovf_nxt = r_ovf;
                end
                default: begin
                    w_acc_nxt = r_s1_p;
                    w_ovf_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock0 or negedge reset) begin
        if (!reset) begin
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_acc       <= w_acc_nxt;
            r_ovf       <= w_ovf_nxt;
            r_out_valid <= r_s1_valid;
        end
    end

    assign z         = r_acc;
    assign overflow  = r_ovf;
    assign out_valid = r_out_valid;
    assign parity    = ^r_acc;

endmodule
